// File: rtl/rx_byte_fifo.sv
// Receive-side byte FIFO behind the UART receiver.
// A rising edge on rx_ready pushes rx_data. The consumer side is first-word-fall-through
// valid/ready. The block also reports fill level and a sticky overflow flag.
module rx_byte_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_ready,
   input  logic              out_ready,
   input  logic              clr_ovf,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic              rx_ready_d;
   logic              overflow_q;

   logic push;
   logic pop;
   logic do_write;
   logic drop;

   // Status and read-side outputs come only from registered state.
   always_comb begin
      full      = (count_q == FullCount);
      empty     = (count_q == '0);
      out_valid = ~empty;
      out_data  = out_valid ? mem[rd_ptr] : '0;
      count     = count_q;
      overflow  = overflow_q;
   end

   // Decode push, pop, write and drop for this cycle.
   // A push into a full buffer still proceeds when a pop frees the slot in the same cycle.
   always_comb begin
      push     = rx_ready & ~rx_ready_d;
      pop      = out_valid & out_ready;
      do_write = push & (~full | pop);
      drop     = push & full & ~pop;
   end

   // Edge detector history.
   // It resets to 1 so that a level already high out of reset is not taken as a new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ready_d <= 1'b1;
      end else begin
         rx_ready_d <= rx_ready;
      end
   end

   // Storage array; its contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   // Pointers and fill count.
   // Both pointers wrap through natural ADDR_W-bit rollover.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_write, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky overflow flag.
   // If a drop and a clear happen in the same cycle, the set takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (clr_ovf) begin
         overflow_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo.
// It runs a vector table for reset and ordering, then hand sequences for fill, overflow,
// a simultaneous push and pop at full, pointer wrap-around and an asynchronous reset.
module tb_rx_byte_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       out_ready;
   logic       clr_ovf;
   logic       out_valid;
   logic [7:0] out_data;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   rx_byte_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .out_ready (out_ready),
      .clr_ovf   (clr_ovf),
      .out_valid (out_valid),
      .out_data  (out_data),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rr;
      logic [7:0] din;
      logic       ordy;
      logic       clr;
      logic       v;
      logic [7:0] d;
      logic [4:0] c;
      logic       f;
      logic       e;
      logic       o;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic v, input logic [7:0] d, input logic [4:0] c,
                      input logic f, input logic e, input logic o);
      total++;
      if ({out_valid, out_data, count, full, empty, overflow} !== {v, d, c, f, e, o}) begin
         bad++;
         $display("FAIL %s: got v=%b d=%h c=%0d f=%b e=%b o=%b, want v=%b d=%h c=%0d f=%b e=%b o=%b",
                  name, out_valid, out_data, count, full, empty, overflow, v, d, c, f, e, o);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lower rx_ready for one sampled cycle, then raise it with byte b.
   task automatic push_byte(input logic [7:0] b);
      rx_ready = 1'b0;
      tick();
      rx_ready = 1'b1;
      rx_data  = b;
      tick();
   endtask

   initial begin
      // Reset and level-high vectors.
      vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0};
      // Ordering vectors.
      vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 5'd2, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 5'd2, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 5'd3, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 8'h02, 5'd2, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0};

      // Hold rx_ready high through reset.
      rst       = 1'b1;
      rx_ready  = 1'b1;
      rx_data   = 8'h00;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_state", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 14; i++) begin
         rx_ready  = vecs[i].rr;
         rx_data   = vecs[i].din;
         out_ready = vecs[i].ordy;
         clr_ovf   = vecs[i].clr;
         tick();
         chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].f, vecs[i].e,
             vecs[i].o);
      end
      clr_ovf   = 1'b0;
      out_ready = 1'b0;

      // Push 17 bytes. The last one is dropped and raises overflow.
      for (int i = 0; i < 17; i++) begin
         push_byte(8'(i));
      end
      chk("fill_ovf", 1'b1, 8'h00, 5'd16, 1'b1, 1'b0, 1'b1);
      rx_ready  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d", i), 1'b1, 8'(i), 5'(16 - i), i == 0, 1'b0, 1'b1);
         tick();
      end
      out_ready = 1'b0;
      chk("drain_empty", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr_ovf", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);

      // Push while full with a simultaneous pop. The count holds and no byte is dropped.
      for (int i = 0; i < 16; i++) begin
         push_byte(8'h30 + 8'(i));
      end
      chk("refill", 1'b1, 8'h30, 5'd16, 1'b1, 1'b0, 1'b0);
      rx_ready = 1'b0;
      tick();
      rx_ready  = 1'b1;
      rx_data   = 8'hAA;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("simul_full", 1'b1, 8'h31, 5'd16, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("simul_drain%0d", i), 1'b1, (i < 15) ? 8'h31 + 8'(i) : 8'hAA,
             5'(16 - i), i == 0, 1'b0, 1'b0);
         tick();
      end
      out_ready = 1'b0;
      chk("simul_empty", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);

      // A drop in the same cycle as clr_ovf leaves overflow set.
      for (int i = 0; i < 16; i++) begin
         push_byte(8'h40 + 8'(i));
      end
      rx_ready = 1'b0;
      tick();
      rx_ready = 1'b1;
      rx_data  = 8'hEE;
      clr_ovf  = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("set_wins", 1'b1, 8'h40, 5'd16, 1'b1, 1'b0, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
      end
      out_ready = 1'b0;
      clr_ovf   = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("set_wins_clear", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);

      // Interleaved push and pop across several pointer wraps.
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         push_byte(8'(i));
         chk($sformatf("wrap%0d", i), 1'b1, 8'(i), 5'd1, 1'b0, 1'b0, 1'b0);
      end
      rx_ready = 1'b0;
      tick();
      out_ready = 1'b0;
      chk("wrap_empty", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);

      // Assert an asynchronous reset between clock edges with five bytes stored.
      for (int i = 0; i < 5; i++) begin
         push_byte(8'h70 + 8'(i));
      end
      chk("pre_rst", 1'b1, 8'h70, 5'd5, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      rst = 1'b0;
      tick();
      chk("post_rst_hold", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);
      push_byte(8'h3C);
      chk("post_rst_push", 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_byte_fifo.md
# rx_byte_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It detects each new-frame event on the receiver's `rx_ready` level, captures `rx_data` into a DEPTH-entry circular buffer, and presents bytes to the consumer over a first-word-fall-through valid/ready interface. It also reports fill level and a sticky overflow flag, so bytes lost to a slow consumer are observable.

## Interface
Parameters:
- `DATA_W`, 8: byte width; must equal the receiver's data width.
- `DEPTH`, 16: number of entries; power of 2, ≥ 2.
- `ADDR_W`, 4: log2(DEPTH); pointer width.

Ports:
- `clk`  in  1: system clock. One clock domain only.
- `rst`  in  1: asynchronous, active-high reset.
- `rx_data`  in  DATA_W: received byte from the receiver; valid while `rx_ready` is high.
- `rx_ready`  in  1: receiver level flag.
  - Goes high when a frame completes.
  - Stays high while the receiver is idle.
  - Drops while the next frame is being received.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `clr_ovf`  in  1: synchronous clear of `overflow`.
- `out_valid`  out  1: buffer non-empty; `out_data` is valid.
- `out_data`  out  DATA_W: oldest stored byte; 0 when empty.
- `count`  out  ADDR_W+1: entries held, 0..DEPTH.
- `full`  out  1: `count == DEPTH`.
- `empty`  out  1: `count == 0`.
- `overflow`  out  1: sticky; a byte was dropped because the buffer was full.

## Operation
Edge detect:
- Register `rx_ready_d`; it is reset to 1.
- `push = rx_ready & ~rx_ready_d`.
- Resetting `rx_ready_d` to 1 means a level already high out of reset is never captured as a new byte.

Storage:
- `mem[DEPTH]`, write pointer `wr_ptr`, read pointer `rd_ptr`, each ADDR_W bits.
- Both pointers wrap modulo DEPTH (natural ADDR_W-bit rollover).
- `count` is a separate ADDR_W+1-bit register.

Read side:
- `pop = out_valid & out_ready`.
- `out_valid = ~empty`.
- `out_data = mem[rd_ptr]` when `out_valid`, else 0.

Per-clock update:
- **push only, not full:** write `mem[wr_ptr] <= rx_data`, `wr_ptr+1`, `count+1`.
- **push only, full:** byte dropped; `overflow <= 1`; pointers and `count` unchanged.
- **pop only:** `rd_ptr+1`, `count-1`.
- **push and pop, any fill including full:** write and read both proceed; `count` unchanged; no overflow.
- **neither:** hold all state.

Overflow flag:
- `clr_ovf` clears `overflow` to 0.
- If a drop occurs in the same cycle as `clr_ovf`, set wins and `overflow` stays 1.

Status outputs:
- `full`, `empty` and `count` derive from registered state; no combinational path from `rx_ready`.

Reset (async, any time, including mid-burst):
- `wr_ptr`, `rd_ptr`, `count` = 0.
- `overflow` = 0; `rx_ready_d` = 1.
- Outputs at reset: `out_valid` = 0, `out_data` = 0, `empty` = 1, `full` = 0.
- `mem` contents are not reset.

## Timing
- Write latency: `rx_ready` rising and sampled at edge N → byte written at edge N → `out_valid` = 1, `out_data` = byte, `count` incremented in the cycle after edge N.
- `rx_ready` held high for many cycles produces exactly one push.
- A new push requires `rx_ready` to go low for at least one sampled cycle.
- Pop: `out_ready` high while `out_valid` at edge M → the next entry, or 0/`out_valid` = 0, appears after edge M.
- FWFT: no read latency; data is visible as soon as it is stored.
- `out_ready` while empty has no effect.
- Sustained throughput: one push and one pop per clock.

## Test plan
- **Reset / level high:** assert `rst` with `rx_ready` = 1 held, then release.
  - Required: `count` = 0, `empty` = 1, no push.
  - Drop `rx_ready` then raise it with `rx_data` = 0x55 → `count` = 1, `out_data` = 0x55.
- **Ordering:** push 0x01, 0x02, 0x03 with `out_ready` = 0, then `out_ready` = 1.
  - Required: `out_data` sequence 0x01, 0x02, 0x03; `empty` = 1 after 3 pops; `out_data` = 0.
- **Fill and overflow:** push DEPTH+1 bytes 0x00..0x10 (DEPTH = 16).
  - Required: `full` = 1, `count` = 16, `overflow` = 1; drain yields 0x00..0x0F; 0x10 lost.
  - Then pulse `clr_ovf` → `overflow` = 0.
- **Simultaneous at full:** with `full` = 1 and `out_ready` = 1, push 0xAA.
  - Required: `count` stays 16, `overflow` stays 0; 0xAA is the last byte drained.
- **Wrap-around:** push and pop 40 bytes 0x00..0x27 interleaved.
  - Required: read data matches order through pointer wrap; `count` never exceeds 2.
- **Reset mid-operation:** with 5 bytes stored, pulse `rst` asynchronously between clock edges.
  - Required: `out_valid` = 0, `count` = 0 immediately.
  - The next push of 0x3C reads back as 0x3C.
